// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer for writeback, flag register and branch condition.
// Optional statistics counters are enabled with `define ALU_RES_STATS_EN.
module alu_result_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic [4:0]    in_flags,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic          in_setflags,
    input  logic          flush,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rd,
    output logic          wb_we,
    output logic [4:0]    flags_q,
    input  logic [2:0]    cond_sel,
    output logic          cond_true
`ifdef ALU_RES_STATS_EN
    ,
    output logic [31:0]   stat_retired,
    output logic [31:0]   stat_stall
`endif
);

    // state | meaning
    // EMPTY | no entries buffered
    // ONE   | head entry valid
    // TWO   | head and skid entries valid, input stalled
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] head_data, skid_data;
    logic [RW-1:0] head_rd, skid_rd;
    logic          head_we, skid_we;
    logic          accept, retire, in_we_eff;

    assign in_ready  = (state != S_TWO);
    assign wb_valid  = (state != S_EMPTY);
    assign wb_data   = head_data;
    assign wb_rd     = head_rd;
    assign wb_we     = head_we;

    // An accept coinciding with flush is dropped entirely, flag update included.
    assign accept    = in_valid & in_ready & ~flush;
    assign retire    = wb_valid & wb_ready;
    assign in_we_eff = in_we & (in_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            head_data <= '0;
            head_rd   <= '0;
            head_we   <= 1'b0;
            skid_data <= '0;
            skid_rd   <= '0;
            skid_we   <= 1'b0;
            flags_q   <= '0;
        end else begin
            if (accept && in_setflags)
                flags_q <= in_flags;
            if (flush) begin
                state <= S_EMPTY;
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (accept) begin
                            head_data <= in_result;
                            head_rd   <= in_rd;
                            head_we   <= in_we_eff;
                            state     <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (accept && retire) begin
                            head_data <= in_result;
                            head_rd   <= in_rd;
                            head_we   <= in_we_eff;
                        end else if (accept) begin
                            skid_data <= in_result;
                            skid_rd   <= in_rd;
                            skid_we   <= in_we_eff;
                            state     <= S_TWO;
                        end else if (retire) begin
                            state <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (retire) begin
                            head_data <= skid_data;
                            head_rd   <= skid_rd;
                            head_we   <= skid_we;
                            state     <= S_ONE;
                        end
                    end
                    default: state <= S_EMPTY;
                endcase
            end
        end
    end

    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags_q[4];
            3'd2: cond_true = ~flags_q[4];
            3'd3: cond_true = flags_q[1];
            3'd4: cond_true = flags_q[0];
            3'd5: cond_true = ~flags_q[0];
            3'd6: cond_true = ~flags_q[1];
            3'd7: cond_true = flags_q[3];
            default: cond_true = 1'b1;
        endcase
    end

`ifdef ALU_RES_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_retired <= '0;
            stat_stall   <= '0;
        end else begin
            if (retire)
                stat_retired <= stat_retired + 32'd1;
            if (in_valid && !in_ready)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a writeback scoreboard and flag model.
// Build with +define+ALU_RES_STATS_EN to also check the statistics counters.
module tb_alu_result_stage;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic [4:0]  in_rd;
    logic        in_we, in_setflags, flush;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [4:0]  flags_q;
    logic [2:0]  cond_sel;
    logic        cond_true;
`ifdef ALU_RES_STATS_EN
    logic [31:0] stat_retired, stat_stall;
    int          exp_ret, exp_stall;
`endif

    wb_t         sb[$];
    wb_t         hd;
    logic [4:0]  mon_flags;
    int          n_pass, n_total;
    logic [4:0]  pats [5];

    always #5 clk = ~clk;

    alu_result_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_rd(in_rd), .in_we(in_we),
        .in_setflags(in_setflags), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .flags_q(flags_q),
        .cond_sel(cond_sel), .cond_true(cond_true)
`ifdef ALU_RES_STATS_EN
        , .stat_retired(stat_retired), .stat_stall(stat_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic cond_model(input logic [4:0] f, input logic [2:0] s);
        case (s)
            3'd1: return f[4];
            3'd2: return !f[4];
            3'd3: return f[1];
            3'd4: return f[0];
            3'd5: return !f[0];
            3'd6: return !f[1];
            3'd7: return f[3];
            default: return 1'b1;
        endcase
    endfunction

    // Samples at negedge: checks occupancy, retires against the scoreboard, records accepts.
    task automatic monitor();
        if (rst) begin
            sb.delete();
            mon_flags = '0;
`ifdef ALU_RES_STATS_EN
            exp_ret = 0;
            exp_stall = 0;
`endif
            return;
        end
        check("occupancy", {31'b0, wb_valid}, {31'b0, sb.size() != 0});
        check("flags_q", {27'b0, flags_q}, {27'b0, mon_flags});
        if (wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                check("retire_on_empty", {31'b0, wb_valid}, 32'd0);
            end else begin
                hd = sb.pop_front();
                check("wb_data", wb_data, hd.d);
                check("wb_rd", {27'b0, wb_rd}, {27'b0, hd.rd});
                check("wb_we", {31'b0, wb_we}, {31'b0, hd.we});
            end
`ifdef ALU_RES_STATS_EN
            exp_ret++;
`endif
        end
`ifdef ALU_RES_STATS_EN
        if (in_valid && !in_ready) exp_stall++;
`endif
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back('{d: in_result, rd: in_rd, we: in_we && (in_rd != 5'd0)});
            if (in_setflags) mon_flags = in_flags;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] rd, input logic we,
                         input logic [4:0] f, input logic sf);
        in_valid = 1'b1;
        in_result = d;
        in_rd = rd;
        in_we = we;
        in_flags = f;
        in_setflags = sf;
    endtask

    task automatic drain();
        int cyc;
        in_valid = 1'b0;
        wb_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        mon_flags = '0;
`ifdef ALU_RES_STATS_EN
        exp_ret = 0;
        exp_stall = 0;
`endif
        rst = 1'b1;
        in_valid = 0; in_result = 0; in_flags = 0; in_rd = 0; in_we = 0;
        in_setflags = 0; flush = 0; wb_ready = 0; cond_sel = 0;
        @(posedge clk); #1;
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_wb_we", {31'b0, wb_we}, 32'd0);
        check("rst_flags", {27'b0, flags_q}, 32'd0);
        rst = 1'b0;
        step();

        // single result, one-cycle latency
        wb_ready = 1'b1;
        drive(32'h5, 5'd3, 1'b1, 5'b00010, 1'b1);
        step();
        in_valid = 1'b0;
        check("single_valid", {31'b0, wb_valid}, 32'd1);
        check("single_data", wb_data, 32'h5);
        check("single_rd", {27'b0, wb_rd}, 32'd3);
        check("single_we", {31'b0, wb_we}, 32'd1);
        check("single_flags", {27'b0, flags_q}, 32'b00010);
        cond_sel = 3'd3;
        #1;
        check("single_gt", {31'b0, cond_true}, 32'd1);
        step();
        check("single_empty", {31'b0, wb_valid}, 32'd0);

        // condition sweep over several flag patterns
        pats[0] = 5'b10000; pats[1] = 5'b01000; pats[2] = 5'b00010;
        pats[3] = 5'b00001; pats[4] = 5'b00000;
        for (int p = 0; p < 5; p++) begin
            drive(32'h100 + p, 5'd7, 1'b1, pats[p], 1'b1);
            step();
            in_valid = 1'b0;
            for (int s = 0; s < 8; s++) begin
                cond_sel = s[2:0];
                #1;
                check($sformatf("cond_p%0d_s%0d", p, s), {31'b0, cond_true},
                      {31'b0, cond_model(pats[p], s[2:0])});
                step();
            end
        end
        drive(32'h200, 5'd7, 1'b1, 5'b11111, 1'b0);
        step();
        in_valid = 1'b0;
        check("noset_flags", {27'b0, flags_q}, 32'd0);
        drain();

        // backpressure
        wb_ready = 1'b0;
        drive(32'h11, 5'd1, 1'b1, 5'd0, 1'b0);
        step();
        drive(32'h22, 5'd2, 1'b1, 5'd0, 1'b0);
        step();
        check("bp_ready_two", {31'b0, in_ready}, 32'd0);
        drive(32'h33, 5'd3, 1'b1, 5'd0, 1'b0);
        step();
        check("bp_stall1", {31'b0, in_ready}, 32'd0);
        check("bp_hold_data", wb_data, 32'h11);
        step();
        check("bp_stall2", {31'b0, in_ready}, 32'd0);
        wb_ready = 1'b1;
        step();
        check("bp_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        drain();

        // streaming at full rate
        wb_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(i, 5'(i + 4), 1'b1, 5'd0, 1'b0);
            step();
            check("stream_ready", {31'b0, in_ready}, 32'd1);
            check("stream_data", wb_data, i);
        end
        in_valid = 1'b0;
        drain();

        // rd = 0 never written
        wb_ready = 1'b0;
        drive(32'hFFFF_FFFF, 5'd0, 1'b1, 5'd0, 1'b0);
        step();
        in_valid = 1'b0;
        check("rd0_valid", {31'b0, wb_valid}, 32'd1);
        check("rd0_we", {31'b0, wb_we}, 32'd0);
        drain();

        // flush in TWO with simultaneous setflags accept attempt
        wb_ready = 1'b0;
        drive(32'hA1, 5'd4, 1'b1, 5'b00100, 1'b1);
        step();
        drive(32'hA2, 5'd5, 1'b1, 5'd0, 1'b0);
        step();
        check("fl_two", {31'b0, in_ready}, 32'd0);
        drive(32'hA3, 5'd6, 1'b1, 5'b10000, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'b0, wb_valid}, 32'd0);
        check("fl_ready", {31'b0, in_ready}, 32'd1);
        check("fl_flags", {27'b0, flags_q}, 32'b00100);
        cond_sel = 3'd1;
        #1;
        check("fl_eq", {31'b0, cond_true}, 32'd0);
        step();

        // reset while TWO under backpressure
        drive(32'hB1, 5'd8, 1'b1, 5'b01000, 1'b1);
        step();
        drive(32'hB2, 5'd9, 1'b1, 5'd0, 1'b0);
        step();
        in_valid = 1'b1;
        step();
`ifdef ALU_RES_STATS_EN
        check("stat_retired", stat_retired, exp_ret);
        check("stat_stall", stat_stall, exp_stall);
`endif
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("rr_ready", {31'b0, in_ready}, 32'd1);
        check("rr_valid", {31'b0, wb_valid}, 32'd0);
        check("rr_data", wb_data, 32'd0);
        check("rr_rd", {27'b0, wb_rd}, 32'd0);
        check("rr_we", {31'b0, wb_we}, 32'd0);
        check("rr_flags", {27'b0, flags_q}, 32'd0);
`ifdef ALU_RES_STATS_EN
        check("rr_stat_retired", stat_retired, 32'd0);
        check("rr_stat_stall", stat_stall, 32'd0);
`endif
        rst = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
